memio_bus_ctrl: RTL and testbench

Parametrised memory-mapped I/O controller for the single-cycle MIPS core. It decodes each CPU access into data memory, screen memory, or an on-block I/O register file, and returns read data combinationally in the same cycle. The I/O register file holds a keyboard receive FIFO, a sticky overflow flag, the accelerometer sample, the sound period, a parametrised LED register and a millisecond timer. Both memories are external; this block drives their write enables and word addresses and muxes their read data.

---
 rtl/memio_bus_ctrl.sv | 178 +++++++++++++++++
 tb/tb_memio_bus_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/memio_bus_ctrl.sv
// memio_bus_ctrl: memory-mapped I/O decoder for the single-cycle MIPS core.
// Routes CPU accesses to data memory, screen memory or the local I/O
// register file (keyboard FIFO, overflow flag, accelerometer, sound period,
// LEDs, millisecond timer). Read data is returned combinationally.
// Optional millisecond timer is built only when MEMIO_TIMER_EN is defined.
module memio_bus_ctrl #(
  parameter int unsigned KEYB_DEPTH = 8,
  parameter int unsigned LED_W      = 16,
  parameter int unsigned CLK_HZ     = 100000000,
  parameter int unsigned AW         = 30
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_wr,
  input  logic             cpu_rd,
  input  logic [31:0]      cpu_addr,
  input  logic [31:0]      cpu_writedata,
  output logic [31:0]      cpu_readdata,
  output logic             dmem_wr,
  output logic             smem_wr,
  output logic [AW-1:0]    mem_addr,
  input  logic [31:0]      dmem_readdata,
  input  logic [3:0]       smem_readdata,
  input  logic             keyb_valid,
  input  logic [7:0]       keyb_char,
  input  logic [31:0]      accel_val,
  output logic [31:0]      period,
  output logic [LED_W-1:0] lights
);

  localparam int unsigned PW = (KEYB_DEPTH > 1) ? $clog2(KEYB_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(KEYB_DEPTH);

  typedef enum logic [1:0] {
    RGN_NONE = 2'b00,
    RGN_DMEM = 2'b01,
    RGN_SMEM = 2'b10,
    RGN_IO   = 2'b11
  } region_e;

  typedef enum logic [2:0] {
    SEL_KDATA  = 3'd0,
    SEL_KSTAT  = 3'd1,
    SEL_ACCEL  = 3'd2,
    SEL_PERIOD = 3'd3,
    SEL_LIGHTS = 3'd4,
    SEL_TIMER  = 3'd5,
    SEL_RSV6   = 3'd6,
    SEL_RSV7   = 3'd7
  } io_sel_e;

  region_e w_region;
  io_sel_e w_sel;
  logic    w_io_wr;
  logic    w_empty;
  logic    w_full;
  logic    w_pop;
  logic    w_push;
  logic    w_drop;
  logic    w_unused_ok;
  logic [31:0] w_timer;

  logic [7:0]       r_fifo [KEYB_DEPTH];
  logic [PW-1:0]    r_rptr;
  logic [PW-1:0]    r_wptr;
  logic [CW-1:0]    r_count;
  logic             r_ovf;
  logic [31:0]      r_period;
  logic [LED_W-1:0] r_lights;

  assign w_region    = region_e'(cpu_addr[17:16]);
  assign w_sel       = io_sel_e'(cpu_addr[4:2]);
  assign w_io_wr     = cpu_wr && (w_region == RGN_IO);
  assign dmem_wr     = cpu_wr && (w_region == RGN_DMEM);
  assign smem_wr     = cpu_wr && (w_region == RGN_SMEM);
  assign mem_addr    = cpu_addr[AW+1:2];
  assign period      = r_period;
  assign lights      = r_lights;
  assign w_unused_ok = ^cpu_addr[1:0];

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);
  assign w_pop   = cpu_rd && (w_region == RGN_IO) && (w_sel == SEL_KDATA) && !w_empty;
  // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
  assign w_push  = keyb_valid && (!w_full || w_pop);
  assign w_drop  = keyb_valid && w_full && !w_pop;

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      // A character lost in the same cycle as a KSTAT write keeps the flag set.
      if (w_drop)
        r_ovf <= 1'b1;
      else if (w_io_wr && (w_sel == SEL_KSTAT))
        r_ovf <= 1'b0;
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wptr] <= keyb_char;
  end

  // Writable I/O registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_period <= '0;
      r_lights <= '0;
    end else if (w_io_wr) begin
      if (w_sel == SEL_PERIOD) r_period <= cpu_writedata;
      if (w_sel == SEL_LIGHTS) r_lights <= cpu_writedata[LED_W-1:0];
    end
  end

`ifdef MEMIO_TIMER_EN
  localparam int unsigned PRESC_MAX = (CLK_HZ / 1000 > 0) ? (CLK_HZ / 1000 - 1) : 0;

  logic [31:0] r_presc;
  logic [31:0] r_timer;

  // Millisecond timer; a CPU write overrides a same-cycle tick
  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc <= '0;
      r_timer <= '0;
    end else if (w_io_wr && (w_sel == SEL_TIMER)) begin
      r_presc <= '0;
      r_timer <= cpu_writedata;
    end else if (r_presc == PRESC_MAX) begin
      r_presc <= '0;
      r_timer <= r_timer + 32'd1;
    end else begin
      r_presc <= r_presc + 32'd1;
    end
  end

  assign w_timer = r_timer;
`else
  logic w_unused_clk_hz;
  assign w_unused_clk_hz = (CLK_HZ != 0);
  assign w_timer         = '0;
`endif

  // Combinational read-data mux
  always_comb begin
    cpu_readdata = '0;
    case (w_region)
      RGN_DMEM: cpu_readdata = dmem_readdata;
      RGN_SMEM: cpu_readdata = {28'b0, smem_readdata};
      RGN_IO: begin
        case (w_sel)
          SEL_KDATA:  cpu_readdata = w_empty ? '0 : {24'b0, r_fifo[r_rptr]};
          SEL_KSTAT:  cpu_readdata = {23'b0, r_ovf, 8'(r_count)};
          SEL_ACCEL:  cpu_readdata = accel_val;
          SEL_PERIOD: cpu_readdata = r_period;
          SEL_LIGHTS: cpu_readdata = 32'(r_lights);
          SEL_TIMER:  cpu_readdata = w_timer;
          default:    cpu_readdata = '0;
        endcase
      end
      default: cpu_readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_memio_bus_ctrl.sv
// Self-checking bench for memio_bus_ctrl: directed scenarios followed by
// random traffic, with expected responses queued by a reference model and
// checked by an independent monitor. Timer expectations follow MEMIO_TIMER_EN.
module tb_memio_bus_ctrl;

  localparam int DEPTH = 8;
  localparam int LEDW  = 16;
  localparam int CLKHZ = 4000;
  localparam int PRE   = CLKHZ / 1000;
`ifdef MEMIO_TIMER_EN
  localparam bit TIMER_ON = 1'b1;
`else
  localparam bit TIMER_ON = 1'b0;
`endif

  localparam logic [31:0] A_KDATA  = 32'h0003_0000;
  localparam logic [31:0] A_KSTAT  = 32'h0003_0004;
  localparam logic [31:0] A_ACCEL  = 32'h0003_0008;
  localparam logic [31:0] A_PERIOD = 32'h0003_000C;
  localparam logic [31:0] A_LIGHTS = 32'h0003_0010;
  localparam logic [31:0] A_TIMER  = 32'h0003_0014;

  logic            clk = 1'b0;
  logic            reset, cpu_wr, cpu_rd;
  logic [31:0]     cpu_addr, cpu_writedata, cpu_readdata;
  logic            dmem_wr, smem_wr;
  logic [29:0]     mem_addr;
  logic [31:0]     dmem_readdata;
  logic [3:0]      smem_readdata;
  logic            keyb_valid;
  logic [7:0]      keyb_char;
  logic [31:0]     accel_val;
  logic [31:0]     period;
  logic [LEDW-1:0] lights;

  always #5 clk = ~clk;

  memio_bus_ctrl #(
    .KEYB_DEPTH(DEPTH),
    .LED_W(LEDW),
    .CLK_HZ(CLKHZ),
    .AW(30)
  ) dut (
    .clk(clk), .reset(reset), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
    .cpu_addr(cpu_addr), .cpu_writedata(cpu_writedata), .cpu_readdata(cpu_readdata),
    .dmem_wr(dmem_wr), .smem_wr(smem_wr), .mem_addr(mem_addr),
    .dmem_readdata(dmem_readdata), .smem_readdata(smem_readdata),
    .keyb_valid(keyb_valid), .keyb_char(keyb_char), .accel_val(accel_val),
    .period(period), .lights(lights)
  );

  int total = 0;
  int bad   = 0;

  // Scoreboard queues
  logic [31:0] rd_exp_q[$];
  logic [31:0] wr_exp_q[$];

  // Reference model state
  byte unsigned    m_fifo[$];
  bit              m_ovf;
  logic [31:0]     m_period;
  logic [LEDW-1:0] m_lights;
  logic [31:0]     m_tbase;
  logic [31:0]     m_tcyc;
  bit              m_live = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic [31:0] dm,
                                             input logic [3:0] sm, input logic [31:0] acc);
    logic [31:0] r;
    r = 32'h0;
    case (a[17:16])
      2'b01: r = dm;
      2'b10: r = {28'h0, sm};
      2'b11: begin
        case (a[4:2])
          3'd0: r = (m_fifo.size() == 0) ? 32'h0 : {24'h0, m_fifo[0]};
          3'd1: r = {23'h0, m_ovf, 8'(m_fifo.size())};
          3'd2: r = acc;
          3'd3: r = m_period;
          3'd4: r = 32'(m_lights);
          3'd5: r = TIMER_ON ? (m_tbase + m_tcyc / PRE) : 32'h0;
          default: r = 32'h0;
        endcase
      end
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  // One bus cycle: drive, queue expectations, step the model at the edge
  task automatic cycle(input bit rst, input bit wr, input bit rd,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input bit kv, input logic [7:0] kc,
                       input bit use_exp, input logic [31:0] exp_val);
    bit io, pop;
    logic [2:0] sel;
    reset = rst; cpu_wr = wr; cpu_rd = rd; cpu_addr = addr; cpu_writedata = wdata;
    keyb_valid = kv; keyb_char = kc;
    dmem_readdata = $urandom; smem_readdata = 4'($urandom); accel_val = $urandom;
    if (rd) rd_exp_q.push_back(use_exp ? exp_val :
                               model_read(addr, dmem_readdata, smem_readdata, accel_val));
    if (wr) wr_exp_q.push_back({addr[17:16] == 2'b01, addr[17:16] == 2'b10, addr[31:2]});
    @(posedge clk);
    if (rst) begin
      m_fifo.delete(); m_ovf = 0; m_period = '0; m_lights = '0;
      m_tbase = '0; m_tcyc = '0; m_live = 1'b1;
    end else begin
      io  = (addr[17:16] == 2'b11);
      sel = addr[4:2];
      pop = rd && io && (sel == 3'd0) && (m_fifo.size() > 0);
      if (wr && io && sel == 3'd1) m_ovf = 0;
      if (pop) void'(m_fifo.pop_front());
      if (kv) begin
        if (m_fifo.size() < DEPTH) m_fifo.push_back(kc);
        else m_ovf = 1;
      end
      if (wr && io && sel == 3'd3) m_period = wdata;
      if (wr && io && sel == 3'd4) m_lights = wdata[LEDW-1:0];
      if (TIMER_ON && wr && io && sel == 3'd5) begin
        m_tbase = wdata; m_tcyc = '0;
      end else begin
        m_tcyc = m_tcyc + 1;
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 32'h0, 32'h0, 0, 8'h0, 0, 32'h0);
  endtask
  task automatic rst_cyc();
    cycle(1, 0, 0, 32'h0, 32'h0, 1, 8'h77, 0, 32'h0);
  endtask
  task automatic push_k(input logic [7:0] c);
    cycle(0, 0, 0, 32'h0, 32'h0, 1, c, 0, 32'h0);
  endtask
  task automatic rd_chk(input logic [31:0] a, input logic [31:0] e);
    cycle(0, 0, 1, a, 32'h0, 0, 8'h0, 1, e);
  endtask
  task automatic rd_mdl(input logic [31:0] a);
    cycle(0, 0, 1, a, 32'h0, 0, 8'h0, 0, 32'h0);
  endtask
  task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
    cycle(0, 1, 0, a, d, 0, 8'h0, 0, 32'h0);
  endtask

  // Monitor: compare whatever the DUT presents, away from the active edge
  always @(negedge clk) begin
    if (m_live && !reset) begin
      chk("period", period, m_period);
      chk("lights", 32'(lights), 32'(m_lights));
    end
    if (cpu_rd) begin
      if (rd_exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL rd_queue actual=empty required=entry at %0t", $time);
      end else begin
        chk("readdata", cpu_readdata, rd_exp_q.pop_front());
      end
    end
    if (cpu_wr) begin
      if (wr_exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL wr_queue actual=empty required=entry at %0t", $time);
      end else begin
        chk("wr_strobes", {dmem_wr, smem_wr, mem_addr}, wr_exp_q.pop_front());
      end
    end else begin
      chk("no_wr_strobe", {30'h0, dmem_wr, smem_wr}, 32'h0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    bit r, w, k, rs;
    reset = 1; cpu_wr = 0; cpu_rd = 0; cpu_addr = '0; cpu_writedata = '0;
    dmem_readdata = '0; smem_readdata = '0; keyb_valid = 0; keyb_char = '0; accel_val = '0;

    // Reset state; keyb_valid during reset is discarded
    rst_cyc(); rst_cyc();
    rd_chk(A_KSTAT, 32'h0);
    rd_chk(A_KDATA, 32'h0);

    // Two characters in, two out
    push_k(8'h41); push_k(8'h42);
    rd_chk(A_KSTAT, 32'h2);
    rd_chk(A_KDATA, 32'h41);
    rd_chk(A_KSTAT, 32'h1);
    rd_chk(A_KDATA, 32'h42);
    rd_chk(A_KSTAT, 32'h0);

    // Overflow: ninth char dropped, flag sticky until KSTAT write
    for (int i = 0; i < 9; i++) push_k(8'(8'h30 + i));
    rd_chk(A_KSTAT, 32'h108);
    for (int i = 0; i < 8; i++) rd_chk(A_KDATA, 32'(8'h30 + i));
    rd_chk(A_KDATA, 32'h0);
    rd_chk(A_KSTAT, 32'h100);
    wr_reg(A_KSTAT, 32'h0);
    rd_chk(A_KSTAT, 32'h0);

    // Full FIFO with simultaneous pop and push
    for (int i = 0; i < 8; i++) push_k(8'(8'h60 + i));
    cycle(0, 0, 1, A_KDATA, 32'h0, 1, 8'h55, 1, 32'h60);
    rd_chk(A_KSTAT, 32'h8);
    for (int i = 1; i < 8; i++) rd_chk(A_KDATA, 32'(8'h60 + i));
    rd_chk(A_KDATA, 32'h55);
    rd_chk(A_KSTAT, 32'h0);
    // Empty FIFO with simultaneous pop and push: push accepted
    cycle(0, 0, 1, A_KDATA, 32'h0, 1, 8'h66, 1, 32'h0);
    rd_chk(A_KSTAT, 32'h1);
    rd_chk(A_KDATA, 32'h66);

    // LEDs, period, memory strobes, unmapped region
    wr_reg(A_LIGHTS, 32'h0003_FFFF);
    rd_chk(A_LIGHTS, 32'h0000_FFFF);
    wr_reg(A_PERIOD, 32'h0001_E848);
    rd_chk(A_PERIOD, 32'h0001_E848);
    wr_reg(32'h0001_0008, 32'hDEAD_BEEF);
    wr_reg(32'h0002_0010, 32'h5);
    wr_reg(32'h1000_0008, 32'h1);
    rd_chk(32'h1000_0008, 32'h0);
    rd_mdl(32'h0001_0008);
    rd_mdl(32'h0002_0004);
    rd_mdl(A_ACCEL);
    rd_chk(32'h0003_0018, 32'h0);
    rd_chk(32'h0003_001C, 32'h0);

    // Timer
    rst_cyc();
    idle(12);
    rd_chk(A_TIMER, TIMER_ON ? 32'd3 : 32'd0);
    wr_reg(A_TIMER, 32'd100);
    rd_chk(A_TIMER, TIMER_ON ? 32'd100 : 32'd0);
    idle(3);
    rd_chk(A_TIMER, TIMER_ON ? 32'd101 : 32'd0);
    wr_reg(A_TIMER, 32'hFFFF_FFFF);
    idle(4);
    rd_chk(A_TIMER, TIMER_ON ? 32'd0 : 32'd0);

    // Random traffic against the model
    for (int n = 0; n < 800; n++) begin
      a = $urandom;
      a[17:16] = ($urandom_range(0, 1) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a[4:2]   = ($urandom_range(0, 2) == 0) ? 3'd0 : 3'($urandom_range(0, 7));
      rs = ($urandom_range(0, 199) == 0);
      r  = rs ? 1'b0 : 1'($urandom_range(0, 1));
      w  = ($urandom_range(0, 3) == 0);
      k  = ($urandom_range(0, 2) == 0);
      cycle(rs, w, r, a, $urandom, k, 8'($urandom), 0, 32'h0);
    end
    idle(2);

    total++;
    if (rd_exp_q.size() != 0 || wr_exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover actual=%0d/%0d required=0/0", rd_exp_q.size(), wr_exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
